// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory req/ack port and decoder-facing valid/ready port of the fetch unit
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        dobranch;
    logic        dojump;
    logic        dojumpreg;
    logic [31:0] jr_target;
    logic        addr_err;
    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, addr_err,
        input  imem_ack, imem_rdata, instr_ready, dobranch, dojump, dojumpreg, jr_target
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, addr_err,
        output imem_ack, imem_rdata, instr_ready, dobranch, dojump, dojumpreg, jr_target
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC and fetch FSM over req/ack imem and valid/ready decoder ports; `define PREFETCH_EN adds a one-entry prefetch buffer
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
`ifdef PREFETCH_EN
    typedef enum logic [1:0] {S_FETCH, S_VALID, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_VALID} state_t;
`endif
    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, instr_q, instr_d;
    logic [31:0] pc_plus4, next_pc;
    logic        addr_err_q, addr_err_d, consume, ack;
`ifdef PREFETCH_EN
    logic        pf_valid_q, pf_valid_d, redirect;
    logic [31:0] pf_data_q, pf_data_d;
    assign redirect      = bus.dojumpreg | bus.dojump | bus.dobranch;
    assign bus.imem_req  = reset & ((state_q != S_VALID) | ~pf_valid_q);
    assign bus.imem_addr = (state_q == S_FETCH) ? fetch_pc_q : pc_plus4;
`else
    assign bus.imem_req  = reset & (state_q == S_FETCH);
    assign bus.imem_addr = fetch_pc_q;
`endif
    assign pc_plus4        = pc_q + 32'd4;
    assign ack             = bus.imem_ack & bus.imem_req;
    assign bus.instr_valid = reset & (state_q == S_VALID);
    assign consume         = bus.instr_valid & bus.instr_ready;
    assign bus.instr       = instr_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.addr_err    = addr_err_q;
    assign next_pc = bus.dojumpreg ? {bus.jr_target[31:2], 2'b00}
                   : bus.dojump    ? {pc_plus4[31:28], instr_q[25:0], 2'b00}
                   : bus.dobranch  ? pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00}
                   : pc_plus4;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = consume & bus.dojumpreg & (|bus.jr_target[1:0]);
`ifdef PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_data_d  = pf_data_q;
`endif
        case (state_q)
            S_FETCH: if (ack) begin
                instr_d = bus.imem_rdata;
                pc_d    = fetch_pc_q;
                state_d = S_VALID;
            end
`ifdef PREFETCH_EN
            S_VALID: if (consume && !redirect && (pf_valid_q || ack)) begin
                instr_d    = pf_valid_q ? pf_data_q : bus.imem_rdata;
                pc_d       = pc_plus4;
                pf_valid_d = 1'b0;
            end else if (consume) begin
                // an unfinished speculative request must complete before the redirect target is fetched
                fetch_pc_d = next_pc;
                pf_valid_d = 1'b0;
                state_d    = (redirect && bus.imem_req && !ack) ? S_DRAIN : S_FETCH;
            end else if (ack) begin
                pf_valid_d = 1'b1;
                pf_data_d  = bus.imem_rdata;
            end
            S_DRAIN: if (ack) state_d = S_FETCH;
`else
            S_VALID: if (consume) begin
                fetch_pc_d = next_pc;
                state_d    = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            addr_err_q <= 1'b0;
`ifdef PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
`ifdef PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_data_q  <= pf_data_d;
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus a randomized run checked against an instruction-stream model
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat_fix = 0;
    bit   poison = 1'b0;
    int   rsp_cnt = 0;
    int   rsp_lat = 0;
    bit   rsp_req_prev = 1'b0;
    logic [31:0] ovr [logic [31:0]];

    instr_fetch_if bus();
    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // memory model: ack after rsp_lat waiting cycles per request (lat_fix < 0 picks randomly)
    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (poison) begin
                bus.imem_ack = 1'b1;
                bus.imem_rdata = 32'hDEAD_BEEF;
            end else begin
                if (bus.imem_req && rsp_req_prev && !bus.imem_ack) rsp_cnt++;
                else begin
                    rsp_cnt = 0;
                    rsp_lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
                end
                bus.imem_ack = bus.imem_req && (rsp_cnt >= rsp_lat);
                bus.imem_rdata = mem_word(bus.imem_addr);
            end
            rsp_req_prev = bus.imem_req;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int lat);
        bus.instr_ready = 0; bus.dobranch = 0; bus.dojump = 0; bus.dojumpreg = 0; bus.jr_target = '0;
        lat_fix = lat;
        reset = 0;
        repeat (3) cyc();
        reset = 1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.instr_valid === 1'b1) begin
                ok = 1;
                break;
            end
            cyc();
        end
    endtask

    task automatic consume(input bit br, input bit j, input bit jr, input logic [31:0] tgt);
        bus.instr_ready = 1; bus.dobranch = br; bus.dojump = j; bus.dojumpreg = jr; bus.jr_target = tgt;
        cyc();
        bus.instr_ready = 0; bus.dobranch = 0; bus.dojump = 0; bus.dojumpreg = 0;
        #3;
    endtask

    task automatic test_reset();
        bit ok;
        bus.instr_ready = 1; bus.dobranch = 0; bus.dojump = 0; bus.dojumpreg = 0; bus.jr_target = '0;
        reset = 0; poison = 1; lat_fix = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(); #3;
            vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
            vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid); end
            vectors++; if (bus.instr !== 32'h0 || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL rst_instr: got %h/%b want 0/0", bus.instr, bus.addr_err); end
        end
        cyc();
        reset = 1; poison = 0; bus.instr_ready = 0;
        #3;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_first_req: got %b@%h want 1@0", bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_valid_timeout: got none want valid"); end
        vectors++; if (bus.pc !== 32'h0 || bus.instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL rst_first_instr: got %h/%h want 0/%h", bus.pc, bus.instr, mem_word(32'h0)); end
    endtask

    task automatic test_zero_wait();
        bit e_valid, e_req;
        logic [31:0] e_addr, e_pc;
        apply_reset(0);
        bus.instr_ready = 1;
        for (int k = 0; k < 12; k++) begin
            #3;
`ifdef PREFETCH_EN
            e_valid = (k > 0); e_req = 1'b1; e_addr = 32'(4 * k); e_pc = 32'(4 * (k - 1));
`else
            e_valid = (k % 2 == 1); e_req = (k % 2 == 0); e_addr = 32'(2 * k); e_pc = 32'(2 * (k - 1));
`endif
            vectors++; if (bus.instr_valid !== e_valid || bus.imem_req !== e_req) begin miscompares++; $display("FAIL zw_hs k=%0d: got v%b r%b want v%b r%b", k, bus.instr_valid, bus.imem_req, e_valid, e_req); end
            if (e_req) begin vectors++; if (bus.imem_addr !== e_addr) begin miscompares++; $display("FAIL zw_addr k=%0d: got %h want %h", k, bus.imem_addr, e_addr); end end
            if (e_valid) begin vectors++; if (bus.pc !== e_pc || bus.instr !== mem_word(e_pc)) begin miscompares++; $display("FAIL zw_instr k=%0d: got %h/%h want %h/%h", k, bus.pc, bus.instr, e_pc, mem_word(e_pc)); end end
            cyc();
        end
        bus.instr_ready = 0;
    endtask

    task automatic test_latency();
        apply_reset(3);
        for (int k = 0; k < 4; k++) begin
            #3;
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL lat_req k=%0d: got r%b@%h v%b want r1@0 v0", k, bus.imem_req, bus.imem_addr, bus.instr_valid); end
            cyc();
        end
        for (int k = 0; k < 5; k++) begin
            #3;
            vectors++; if (bus.instr_valid !== 1'b1 || bus.pc !== 32'h0 || bus.instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL lat_hold k=%0d: got v%b %h/%h want v1 0/%h", k, bus.instr_valid, bus.pc, bus.instr, mem_word(32'h0)); end
`ifdef PREFETCH_EN
            vectors++; if (bus.imem_req === 1'b1 && bus.imem_addr !== 32'h4) begin miscompares++; $display("FAIL lat_pf_addr k=%0d: got %h want 4", k, bus.imem_addr); end
`else
            vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL lat_noreq k=%0d: got %b want 0", k, bus.imem_req); end
`endif
            cyc();
        end
    endtask

    task automatic test_branch();
        bit ok;
        ovr[32'h10] = 32'h1000_FFFE;
        apply_reset(0);
        wait_valid(ok);
        consume(0, 0, 1, 32'h10);
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL br_hop: got r%b@%h e%b want r1@10 e0", bus.imem_req, bus.imem_addr, bus.addr_err); end
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h10 || bus.instr !== 32'h1000_FFFE || bus.pc_plus4 !== 32'h14) begin miscompares++; $display("FAIL br_at10: got %h/%h/%h want 10/1000fffe/14", bus.pc, bus.instr, bus.pc_plus4); end
        consume(1, 0, 0, 32'h0);
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0C) begin miscompares++; $display("FAIL br_taken: got r%b@%h want r1@0c", bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        consume(0, 0, 1, 32'h10);
        wait_valid(ok);
        consume(0, 0, 0, 32'h0);
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h14 || bus.instr !== mem_word(32'h14)) begin miscompares++; $display("FAIL br_not_taken: got %h/%h want 14/%h", bus.pc, bus.instr, mem_word(32'h14)); end
    endtask

    task automatic test_jump();
        bit ok;
        ovr[32'h1000_0040] = 32'h0800_0100;
        apply_reset(0);
        wait_valid(ok);
        consume(0, 0, 1, 32'h1000_0040);
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h1000_0040 || bus.instr !== 32'h0800_0100) begin miscompares++; $display("FAIL j_at: got %h/%h want 10000040/08000100", bus.pc, bus.instr); end
        consume(0, 1, 0, 32'h0);
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1000_0400) begin miscompares++; $display("FAIL j_target: got r%b@%h want r1@10000400", bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        consume(1, 1, 1, 32'h83);
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin miscompares++; $display("FAIL jr_prio: got r%b@%h want r1@80", bus.imem_req, bus.imem_addr); end
        vectors++; if (bus.addr_err !== 1'b1) begin miscompares++; $display("FAIL jr_err_pulse: got %b want 1", bus.addr_err); end
        cyc(); #3;
        vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL jr_err_clear: got %b want 0", bus.addr_err); end
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h80 || bus.instr !== mem_word(32'h80)) begin miscompares++; $display("FAIL jr_at80: got %h/%h want 80/%h", bus.pc, bus.instr, mem_word(32'h80)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset(0);
        wait_valid(ok);
        cyc();
        lat_fix = 20;
        consume(0, 0, 1, 32'h200);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_wait i=%0d: got r%b@%h v%b want r1@200 v0", i, bus.imem_req, bus.imem_addr, bus.instr_valid); end
            cyc(); #3;
        end
        reset = 0; poison = 1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #3;
            vectors++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst: got r%b v%b want r0 v0", bus.imem_req, bus.instr_valid); end
        end
        cyc();
        reset = 1; poison = 0; lat_fix = 0;
        #3;
        vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart: got r%b@%h want r1@0", bus.imem_req, bus.imem_addr); end
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h0 || bus.instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL mid_instr: got %h/%h want 0/%h", bus.pc, bus.instr, mem_word(32'h0)); end
    endtask

`ifdef PREFETCH_EN
    task automatic test_prefetch_drain();
        bit ok;
        int drain;
        ovr[32'h20] = 32'h0800_0040;
        apply_reset(0);
        wait_valid(ok);
        consume(0, 0, 1, 32'h20);
        wait_valid(ok);
        lat_fix = 3;
        vectors++; if (!ok || bus.pc !== 32'h20 || bus.imem_addr !== 32'h24) begin miscompares++; $display("FAIL pf_setup: got %h req@%h want 20 req@24", bus.pc, bus.imem_addr); end
        consume(0, 1, 0, 32'h0);
        drain = 0;
        for (int i = 0; i < 20 && !(bus.imem_req === 1'b1 && bus.imem_addr === 32'h100); i++) begin
            vectors++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h24) begin miscompares++; $display("FAIL pf_drain: got v%b r%b@%h want v0 r1@24", bus.instr_valid, bus.imem_req, bus.imem_addr); end
            drain++;
            cyc(); #3;
        end
        vectors++; if (drain != 3) begin miscompares++; $display("FAIL pf_drain_len: got %0d want 3", drain); end
        wait_valid(ok);
        vectors++; if (!ok || bus.pc !== 32'h100 || bus.instr !== mem_word(32'h100)) begin miscompares++; $display("FAIL pf_target: got %h/%h want 100/%h", bus.pc, bus.instr, mem_word(32'h100)); end
        lat_fix = 0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] e_pc, w, p4, prev_addr;
        bit e_err, pend, cons;
        int idle, consumes;
        apply_reset(-1);
        e_pc = 32'h0; e_err = 0; pend = 0; idle = 0; consumes = 0; prev_addr = '0;
        for (int n = 0; n < 2000; n++) begin
            vectors++; if (bus.addr_err !== e_err) begin miscompares++; $display("FAIL rnd_err n=%0d: got %b want %b", n, bus.addr_err, e_err); end
            if (pend) begin vectors++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin miscompares++; $display("FAIL rnd_hold n=%0d: got r%b@%h want r1@%h", n, bus.imem_req, bus.imem_addr, prev_addr); end end
            if (bus.imem_req === 1'b1) begin vectors++; if (bus.imem_addr[1:0] !== 2'b00) begin miscompares++; $display("FAIL rnd_align n=%0d: got %h want aligned", n, bus.imem_addr); end end
            if (bus.instr_valid === 1'b1) begin
                vectors++;
                if (bus.pc !== e_pc || bus.instr !== mem_word(e_pc) || bus.pc_plus4 !== e_pc + 32'd4) begin
                    miscompares++; $display("FAIL rnd_instr n=%0d: got %h/%h want %h/%h", n, bus.pc, bus.instr, e_pc, mem_word(e_pc));
                end
            end
            bus.instr_ready = ($urandom_range(0, 9) < 6);
            bus.dobranch = ($urandom_range(0, 3) == 0);
            bus.dojump = ($urandom_range(0, 5) == 0);
            bus.dojumpreg = ($urandom_range(0, 5) == 0);
            bus.jr_target = $urandom();
            #2;
            pend = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            cons = bus.instr_valid && bus.instr_ready;
            e_err = cons && bus.dojumpreg && (bus.jr_target[1:0] != 2'b00);
            if (cons) begin
                w = mem_word(e_pc);
                p4 = e_pc + 32'd4;
                if (bus.dojumpreg) e_pc = bus.jr_target & ~32'd3;
                else if (bus.dojump) e_pc = (p4 & 32'hF000_0000) | ({6'd0, w[25:0]} << 2);
                else if (bus.dobranch) e_pc = p4 + 32'(int'($signed(w[15:0])) * 4);
                else e_pc = p4;
                consumes++;
                idle = 0;
            end else idle++;
            if (idle > 60) begin
                vectors++; miscompares++; $display("FAIL rnd_stall n=%0d: got no consume for %0d cycles want progress", n, idle);
                break;
            end
            cyc();
        end
        vectors++; if (consumes < 200) begin miscompares++; $display("FAIL rnd_progress: got %0d consumes want >= 200", consumes); end
        bus.instr_ready = 0; bus.dobranch = 0; bus.dojump = 0; bus.dojumpreg = 0;
    endtask

    initial begin
        bus.instr_ready = 0; bus.dobranch = 0; bus.dojump = 0; bus.dojumpreg = 0; bus.jr_target = '0;
        test_reset();
        test_zero_wait();
        test_latency();
        test_branch();
        test_jump();
        test_reset_mid();
`ifdef PREFETCH_EN
        test_prefetch_drain();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit reached");
    end
endmodule
